keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad controller for the 4x4 keypad front end. It sequences the row drives, samples the column lines and debounces each candidate press in the sampled domain. It reports exactly one 4-bit key code per press to the downstream logic over a valid/ready handshake. It replaces per-button debounce instances with a single scanned, shared debounce resource.

## Interface
- SETTLE_CYCLES, 50: cycles a row is driven before its columns are sampled; legal range 1..65535.
- STABLE_CYCLES, 3000: consecutive cycles a column must hold its new level to confirm a press or a release (60 us at 50 MHz); legal range 1..65535.
- CLOCK_50  in  1  system clock; all logic is on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Row  out  4  row drive, active-low; exactly one bit is low at all times.
- Col  in  4  column sense, active-low (pulled up externally), asynchronous to CLOCK_50.
- KeyCode  out  4  code of the confirmed key, Row index * 4 + column index.
- KeyValid  out  1  KeyCode is valid; held until accepted.
- KeyReady  in  1  consumer accepts the code in any cycle where KeyValid && KeyReady.
- KeyHeld  out  1  high from press confirmation until release confirmation.

## Operation
- Col passes through a 2-flop synchronizer (ColS) before any use.
- Row is driven from a 2-bit row index r: Row = ~(4'b0001 << r).
- FSM states: SETTLE, CONFIRM, REPORT, RELEASE.
- SETTLE: a 16-bit counter runs from 0. When count == SETTLE_CYCLES-1, ColS is sampled.
  - If ColS == 4'hF: r increments (3 wraps to 0), the counter clears, and the FSM stays in SETTLE.
  - Otherwise c = the lowest index with ColS[c] == 0, and the FSM goes to CONFIRM with r held.
- CONFIRM: the counter clears on entry and increments each cycle that ColS[c] == 0.
  - If ColS[c] == 1 in any cycle, the press is aborted: r increments and the FSM returns to SETTLE.
  - On the STABLE_CYCLES-th consecutive low cycle: KeyCode <= {r, c}, KeyValid <= 1, KeyHeld <= 1, and the FSM goes to REPORT.
- REPORT: KeyValid and KeyCode hold. On a cycle with KeyReady == 1, KeyValid <= 0 and the FSM goes to RELEASE.
- RELEASE: row r remains driven. The counter clears whenever ColS[c] == 0 and increments whenever ColS[c] == 1.
  - On the STABLE_CYCLES-th consecutive high cycle: KeyHeld <= 0, r increments, and the FSM goes to SETTLE.
- A release that occurs during REPORT is not tracked; counting starts on entry to RELEASE.
- Only column c of row r is watched after candidate selection. All other keys are ignored until release is confirmed, which gives no rollover and no auto-repeat.
- Each press produces exactly one report.

## Timing
- Reset values: Row = 4'b1110, KeyCode = 4'h0, KeyValid = 0, KeyHeld = 0, FSM = SETTLE, r = 0, counter = 0, synchronizer = 4'hF.
- Reset is asynchronous. Assertion in any state forces all reset values immediately, including mid-CONFIRM and mid-REPORT; a pending code is discarded.
- With no key pressed, each row is low for exactly SETTLE_CYCLES cycles. Full scan period = 4 * SETTLE_CYCLES.
- The Col-to-ColS synchronizer adds 2 cycles of latency.
- KeyValid rises on the clock edge after the STABLE_CYCLES-th consecutive low ColS[c] in CONFIRM.
- KeyCode must not change while KeyValid == 1.
- KeyValid falls on the edge after the accepting cycle. It re-rises at the earliest after release confirmation plus a new SETTLE and CONFIRM.
- KeyReady high while KeyValid == 0 has no effect.
- Counter comparisons are 16-bit; the counter never wraps because the FSM exits at its terminal count.

## Test plan
Bench configuration: SETTLE_CYCLES = 4, STABLE_CYCLES = 8. The keypad model drives Col[c] = 0 iff key (r, c) is pressed and Row[r] == 0.

- Reset with no keys -> Row = 1110, KeyValid = 0, KeyCode = 0. After Reset_n rises, Row steps 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
- Press key (2,1) and hold; KeyReady = 1 -> KeyValid pulses exactly once with KeyCode = 9, KeyHeld = 1. After release plus 8 + 2 cycles, KeyHeld = 0 and Row = 0111.
- Bounce: Col[1] low for 5 cycles during row 2, then high -> no KeyValid, KeyHeld stays 0, and scanning resumes with Row = 0111.
- Backpressure: key (2,1) confirmed with KeyReady = 0 for 20 cycles -> KeyValid = 1 and KeyCode = 9 are stable throughout. KeyReady high for 1 cycle -> KeyValid = 0 on the next cycle, with no second report while the key is held.
- Keys (1,0) and (1,3) pressed together -> KeyCode = 4. Pressing (3,2) while (1,0) is held -> no report until (1,0) release is confirmed, then KeyCode = 14.
- Reset_n pulsed low mid-CONFIRM and again mid-REPORT -> immediate reset values each time, and no stale KeyValid after reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, synchronizes the
// column sense lines and shares one debounce counter across all keys.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 50,
  parameter int STABLE_CYCLES = 3000
) (
  input  logic       CLOCK_50,
  input  logic       Reset_n,
  output logic [3:0] Row,
  input  logic [3:0] Col,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  input  logic       KeyReady,
  output logic       KeyHeld
);

  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_REPORT  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  logic [3:0]  col_s1_q, col_s1_d;
  logic [3:0]  col_s_q,  col_s_d;
  logic [1:0]  state_q,  state_d;
  logic [1:0]  r_q,      r_d;
  logic [1:0]  c_q,      c_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q,  key_held_d;
  logic        col_watch;

  // Priority pick of the lowest active-low column.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols);
    logic [1:0] idx;
    if (!cols[0])      idx = 2'd0;
    else if (!cols[1]) idx = 2'd1;
    else if (!cols[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

  assign col_watch = col_s_q[c_q];

  always_comb begin
    col_s1_d    = Col;
    col_s_d     = col_s1_q;
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_held_d  = key_held_q;

    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 16'd0;
          if (col_s_q == 4'hF) begin
            r_d = r_q + 2'd1;
          end else begin
            c_d     = lowest_low(col_s_q);
            state_d = ST_CONFIRM;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_CONFIRM: begin
        if (col_watch) begin
          // Candidate bounced back high: abandon it and move on to the next row.
          cnt_d   = 16'd0;
          r_d     = r_q + 2'd1;
          state_d = ST_SETTLE;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d       = 16'd0;
          key_code_d  = {r_q, c_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = ST_REPORT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_REPORT: begin
        if (KeyReady) begin
          key_valid_d = 1'b0;
          cnt_d       = 16'd0;
          state_d     = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!col_watch) begin
          cnt_d = 16'd0;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d      = 16'd0;
          key_held_d = 1'b0;
          r_d        = r_q + 2'd1;
          state_d    = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        cnt_d   = 16'd0;
        state_d = ST_SETTLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      col_s1_q    <= 4'hF;
      col_s_q     <= 4'hF;
      state_q     <= ST_SETTLE;
      r_q         <= 2'd0;
      c_q         <= 2'd0;
      cnt_q       <= 16'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_s1_q    <= col_s1_d;
      col_s_q     <= col_s_d;
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign Row      = ~(4'b0001 << r_q);
  assign KeyCode  = key_code_q;
  assign KeyValid = key_valid_q;
  assign KeyHeld  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model, a report scoreboard and
// directed press/bounce/backpressure/rollover/reset sequences.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_ready;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int checks    = 0;
  int failures  = 0;
  int n_reports = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[6];

  keypad_scanner #(.SETTLE_CYCLES(4), .STABLE_CYCLES(8)) dut (
    .CLOCK_50 (clk),
    .Reset_n  (rst_n),
    .Row      (row),
    .Col      (col),
    .KeyCode  (key_code),
    .KeyValid (key_valid),
    .KeyReady (key_ready),
    .KeyHeld  (key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (keys[4'(rr * 4 + cc)] && !row[rr]) col[cc] = 1'b0;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted report is popped against the queue, then one cycle passes.
  task automatic tick();
    logic [3:0] e;
    if (rst_n && key_valid && key_ready) begin
      n_reports++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_report code=%0d expected=none", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          failures++;
          $display("FAIL report_code actual=%0d expected=%0d", key_code, e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic press(input int r, input int c);
    keys[4'(r * 4 + c)] = 1'b1;
  endtask

  task automatic unpress(input int r, input int c);
    keys[4'(r * 4 + c)] = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int i = 0;
    while (!key_valid && i < bound) begin
      tick();
      i++;
    end
    chk({name, "_timeout"}, 4'(key_valid), 4'd1);
  endtask

  task automatic wait_held_low(input string name, input int bound);
    int i = 0;
    while (key_held && i < bound) begin
      tick();
      i++;
    end
    chk({name, "_timeout"}, 4'(key_held), 4'd0);
  endtask

  // Waits for the first cycle of a row drive value.
  task automatic wait_row(input string name, input logic [3:0] target, input int bound);
    int i = 0;
    while (row == target && i < bound) begin
      tick();
      i++;
    end
    while (row != target && i < bound) begin
      tick();
      i++;
    end
    chk({name, "_timeout"}, row, target);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_row"},   row,            4'b1110);
    chk({name, "_valid"}, 4'(key_valid),  4'd0);
    chk({name, "_code"},  key_code,       4'h0);
    chk({name, "_held"},  4'(key_held),   4'd0);
  endtask

  initial begin
    int base;
    logic [3:0] er;

    vecs[0] = '{r: 2, c: 1, code: 4'd9};
    vecs[1] = '{r: 0, c: 0, code: 4'd0};
    vecs[2] = '{r: 3, c: 3, code: 4'd15};
    vecs[3] = '{r: 1, c: 2, code: 4'd6};
    vecs[4] = '{r: 0, c: 3, code: 4'd3};
    vecs[5] = '{r: 3, c: 0, code: 4'd12};

    rst_n     = 1'b0;
    keys      = 16'h0000;
    key_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Idle scan: each row low for exactly 4 cycles.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      er = ~(4'b0001 << ((i / 4) % 4));
      chk("scan_row", row, er);
      tick();
    end

    // Single press of (2,1) with exact release timing.
    key_ready = 1'b1;
    base = n_reports;
    exp_q.push_back(4'd9);
    press(2, 1);
    wait_valid("p21", 200);
    chk("p21_held", 4'(key_held), 4'd1);
    chk("p21_code", key_code, 4'd9);
    tick();
    chk("p21_pulse", 4'(key_valid), 4'd0);
    repeat (3) tick();
    unpress(2, 1);
    repeat (9) tick();
    chk("p21_held_before", 4'(key_held), 4'd1);
    tick();
    chk("p21_held_after", 4'(key_held), 4'd0);
    chk("p21_row_after", row, 4'b0111);
    chk_int("p21_reports", n_reports - base, 1);

    // Bounce: 5 low cycles in row 2 never confirm.
    base = n_reports;
    wait_row("bounce", 4'b1011, 40);
    press(2, 1);
    repeat (5) tick();
    unpress(2, 1);
    repeat (2) tick();
    chk("bounce_row_hold", row, 4'b1011);
    chk("bounce_held", 4'(key_held), 4'd0);
    tick();
    chk("bounce_row_next", row, 4'b0111);
    repeat (30) tick();
    chk("bounce_valid", 4'(key_valid), 4'd0);
    chk_int("bounce_reports", n_reports - base, 0);

    // Table of single-key presses.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].code);
      press(vecs[v].r, vecs[v].c);
      wait_valid("vec", 200);
      chk("vec_code", key_code, vecs[v].code);
      chk("vec_held", 4'(key_held), 4'd1);
      tick();
      repeat (5) tick();
      unpress(vecs[v].r, vecs[v].c);
      wait_held_low("vec_release", 60);
    end

    // Backpressure: code held stable while not accepted.
    key_ready = 1'b0;
    exp_q.push_back(4'd9);
    press(2, 1);
    wait_valid("bp", 200);
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 4'(key_valid), 4'd1);
      chk("bp_code", key_code, 4'd9);
      tick();
    end
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    chk("bp_valid_drop", 4'(key_valid), 4'd0);
    key_ready = 1'b1;
    base = n_reports;
    repeat (30) tick();
    chk_int("bp_no_repeat", n_reports - base, 0);
    chk("bp_held", 4'(key_held), 4'd1);
    unpress(2, 1);
    wait_held_low("bp_release", 60);

    // Two keys in one row, then a locked-out press in another row.
    exp_q.push_back(4'd4);
    press(1, 0);
    press(1, 3);
    wait_valid("multi", 200);
    chk("multi_code", key_code, 4'd4);
    tick();
    unpress(1, 3);
    press(3, 2);
    base = n_reports;
    repeat (40) tick();
    chk_int("lockout_reports", n_reports - base, 0);
    chk("lockout_held", 4'(key_held), 4'd1);
    exp_q.push_back(4'd14);
    unpress(1, 0);
    wait_valid("second", 200);
    chk("second_code", key_code, 4'd14);
    tick();
    unpress(3, 2);
    wait_held_low("second_release", 60);

    // Reset in the middle of CONFIRM.
    wait_row("rc", 4'b1011, 40);
    press(2, 1);
    exp_q.push_back(4'd9);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_confirm");
    exp_q.delete();
    unpress(2, 1);
    @(negedge clk);
    rst_n = 1'b1;
    base = n_reports;
    repeat (30) tick();
    chk("rst_confirm_stale", 4'(key_valid), 4'd0);
    chk_int("rst_confirm_reports", n_reports - base, 0);

    // Reset in the middle of REPORT discards the pending code.
    key_ready = 1'b0;
    exp_q.push_back(4'd9);
    press(2, 1);
    wait_valid("rr", 200);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_report");
    exp_q.delete();
    unpress(2, 1);
    @(negedge clk);
    rst_n = 1'b1;
    key_ready = 1'b1;
    base = n_reports;
    repeat (30) tick();
    chk("rst_report_stale", 4'(key_valid), 4'd0);
    chk_int("rst_report_reports", n_reports - base, 0);
    chk_int("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
